// File: rtl/shift_register_driver_if.sv
// shift_register_driver_if
//   Groups the parallel-load handshake and the three-wire serial chain
//   interface of shift_register_driver.
//   master : the client side; drives dataIn/dataReady and observes status
//            and chain pins.
//   slave  : the driver itself; receives dataIn/dataReady and drives
//            busy/done/dropped plus serialOut/shiftClk/latchClk.
//   Signals:
//     dataIn     [DATA_WIDTH] parallel word, sampled when a transfer starts
//     dataReady  start strobe
//     busy       transfer in progress
//     done       one-cycle pulse after the word has been latched
//     dropped    one-cycle pulse for a request made while busy
//     serialOut  serial data to the chain
//     shiftClk   shift clock to the chain
//     latchClk   storage/latch clock to the chain
interface shift_register_driver_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  dataReady;
    logic                  busy;
    logic                  done;
    logic                  dropped;
    logic                  serialOut;
    logic                  shiftClk;
    logic                  latchClk;

    modport master (
        output dataIn,
        output dataReady,
        input  busy,
        input  done,
        input  dropped,
        input  serialOut,
        input  shiftClk,
        input  latchClk
    );

    modport slave (
        input  dataIn,
        input  dataReady,
        output busy,
        output done,
        output dropped,
        output serialOut,
        output shiftClk,
        output latchClk
    );
endinterface

// File: rtl/shift_register_driver.sv
// shift_register_driver
//   Serialiser for external 74HC595-class shift-register chains. A word
//   accepted on dataReady is shifted out on serialOut, one bit per shiftClk
//   period (CLK_DIV system clocks low, CLK_DIV high), after which latchClk
//   is held high for LATCH_CYCLES clocks and done pulses once.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high reset
//     bus    : shift_register_driver_if.slave (handshake + chain pins)
//   Every output is driven straight from a register.
module shift_register_driver #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLK_DIV      = 4,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    shift_register_driver_if.slave  bus
);

    localparam int BIT_W = (DATA_WIDTH   > 1) ? $clog2(DATA_WIDTH)   : 1;
    localparam int DIV_W = (CLK_DIV      > 1) ? $clog2(CLK_DIV)      : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Bit that goes onto serialOut from the current head of the word.
    function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] word);
        if (MSB_FIRST) begin
            return word[DATA_WIDTH-1];
        end else begin
            return word[0];
        end
    endfunction

    // Discards the bit just shifted so the next one becomes the head.
    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] word);
        if (MSB_FIRST) begin
            return word << 1'b1;
        end else begin
            return word >> 1'b1;
        end
    endfunction

    state_t                r_state, w_state;
    logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt;
    logic [DIV_W-1:0]      r_div_cnt, w_div_cnt;
    logic [LAT_W-1:0]      r_lat_cnt, w_lat_cnt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  r_dropped, w_dropped;
    logic                  r_serial, w_serial;
    logic                  r_sclk, w_sclk;
    logic                  r_lclk, w_lclk;
    logic [DATA_WIDTH-1:0] w_shift_adv;

    assign w_shift_adv = advance(r_shift);

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so that each pin toggles together with its state change.
    always_comb begin
        w_state   = r_state;
        w_bit_cnt = r_bit_cnt;
        w_div_cnt = r_div_cnt;
        w_lat_cnt = r_lat_cnt;
        w_shift   = r_shift;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_serial  = r_serial;
        w_sclk    = r_sclk;
        w_lclk    = r_lclk;
        // Any request seen outside IDLE is refused; nothing is queued.
        w_dropped = bus.dataReady && (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (bus.dataReady) begin
                    w_shift   = bus.dataIn;
                    w_bit_cnt = '0;
                    w_div_cnt = '0;
                    w_busy    = 1'b1;
                    w_serial  = lead_bit(bus.dataIn);
                    w_sclk    = 1'b0;
                    w_lclk    = 1'b0;
                    w_state   = LOW;
                end else begin
                    w_busy   = 1'b0;
                    w_serial = 1'b0;
                    w_sclk   = 1'b0;
                    w_lclk   = 1'b0;
                end
            end
            LOW: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt = '0;
                    w_sclk    = 1'b1;
                    w_state   = HIGH;
                end else begin
                    w_div_cnt = r_div_cnt + 1'b1;
                end
            end
            HIGH: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt = '0;
                    w_sclk    = 1'b0;
                    if (r_bit_cnt == BIT_LAST) begin
                        // Last bit clocked in: serialOut is left as is and
                        // the storage register is strobed.
                        w_lat_cnt = '0;
                        w_lclk    = 1'b1;
                        w_state   = LATCH;
                    end else begin
                        // Data moves only on the falling shiftClk edge,
                        // giving a full low phase of setup time.
                        w_bit_cnt = r_bit_cnt + 1'b1;
                        w_shift   = w_shift_adv;
                        w_serial  = lead_bit(w_shift_adv);
                        w_state   = LOW;
                    end
                end else begin
                    w_div_cnt = r_div_cnt + 1'b1;
                end
            end
            LATCH: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_lclk   = 1'b0;
                    w_busy   = 1'b0;
                    w_done   = 1'b1;
                    w_serial = 1'b0;
                    w_state  = IDLE;
                end else begin
                    w_lat_cnt = r_lat_cnt + 1'b1;
                end
            end
            default: begin
                w_state  = IDLE;
                w_busy   = 1'b0;
                w_serial = 1'b0;
                w_sclk   = 1'b0;
                w_lclk   = 1'b0;
            end
        endcase
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_lat_cnt <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dropped <= 1'b0;
            r_serial  <= 1'b0;
            r_sclk    <= 1'b0;
            r_lclk    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bit_cnt <= w_bit_cnt;
            r_div_cnt <= w_div_cnt;
            r_lat_cnt <= w_lat_cnt;
            r_shift   <= w_shift;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_dropped <= w_dropped;
            r_serial  <= w_serial;
            r_sclk    <= w_sclk;
            r_lclk    <= w_lclk;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dropped   = r_dropped;
    assign bus.serialOut = r_serial;
    assign bus.shiftClk  = r_sclk;
    assign bus.latchClk  = r_lclk;

endmodule

// File: tb/tb_shift_register_driver.sv
// tb_shift_register_driver
//   Five driver instances with different geometries run side by side:
//     u0: 8 bits, CLK_DIV 2, latch 2, MSB first
//     u1: 8 bits, CLK_DIV 2, latch 2, LSB first
//     u2: 4 bits, CLK_DIV 1, latch 2
//     u3: 4 bits, CLK_DIV 3, latch 2
//     u4: 24 bits, CLK_DIV 4, latch 3
//   A transfer-level reference model predicts every pin from the number of
//   cycles since acceptance; each completed transfer is also checked for
//   its length, shiftClk rise count and the bits seen at the rises.
module tb_shift_register_driver;

    localparam int NI = 5;
    localparam int          P_N [NI] = '{8, 8, 4, 4, 24};
    localparam int          P_D [NI] = '{2, 2, 1, 3, 4};
    localparam int          P_L [NI] = '{2, 2, 2, 2, 3};
    localparam int          P_M [NI] = '{1, 0, 1, 1, 1};
    localparam int          EXP_LEN [NI]   = '{34, 34, 10, 26, 195};
    localparam logic [31:0] FIRST_CAP [NI] = '{32'hC4, 32'h23, 32'hA, 32'hA, 32'h800001};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  rst = 5'b11111;
    logic [4:0]  rdy = 5'b00000;
    logic [31:0] din [NI];

    logic [4:0] o_busy, o_done, o_drop, o_ser, o_sclk, o_lclk;

    int n_checks = 0;
    int n_fail   = 0;

    shift_register_driver_if #(.DATA_WIDTH(8))  if0 ();
    shift_register_driver_if #(.DATA_WIDTH(8))  if1 ();
    shift_register_driver_if #(.DATA_WIDTH(4))  if2 ();
    shift_register_driver_if #(.DATA_WIDTH(4))  if3 ();
    shift_register_driver_if #(.DATA_WIDTH(24)) if4 ();

    shift_register_driver #(.DATA_WIDTH(8),  .CLK_DIV(2), .MSB_FIRST(1'b1), .LATCH_CYCLES(2))
        u0 (.clk(clk), .reset(rst[0]), .bus(if0.slave));
    shift_register_driver #(.DATA_WIDTH(8),  .CLK_DIV(2), .MSB_FIRST(1'b0), .LATCH_CYCLES(2))
        u1 (.clk(clk), .reset(rst[1]), .bus(if1.slave));
    shift_register_driver #(.DATA_WIDTH(4),  .CLK_DIV(1), .MSB_FIRST(1'b1), .LATCH_CYCLES(2))
        u2 (.clk(clk), .reset(rst[2]), .bus(if2.slave));
    shift_register_driver #(.DATA_WIDTH(4),  .CLK_DIV(3), .MSB_FIRST(1'b1), .LATCH_CYCLES(2))
        u3 (.clk(clk), .reset(rst[3]), .bus(if3.slave));
    shift_register_driver #(.DATA_WIDTH(24), .CLK_DIV(4), .MSB_FIRST(1'b1), .LATCH_CYCLES(3))
        u4 (.clk(clk), .reset(rst[4]), .bus(if4.slave));

    assign if0.dataIn = din[0][7:0];   assign if0.dataReady = rdy[0];
    assign if1.dataIn = din[1][7:0];   assign if1.dataReady = rdy[1];
    assign if2.dataIn = din[2][3:0];   assign if2.dataReady = rdy[2];
    assign if3.dataIn = din[3][3:0];   assign if3.dataReady = rdy[3];
    assign if4.dataIn = din[4][23:0];  assign if4.dataReady = rdy[4];

    assign o_busy = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
    assign o_done = {if4.done, if3.done, if2.done, if1.done, if0.done};
    assign o_drop = {if4.dropped, if3.dropped, if2.dropped, if1.dropped, if0.dropped};
    assign o_ser  = {if4.serialOut, if3.serialOut, if2.serialOut, if1.serialOut, if0.serialOut};
    assign o_sclk = {if4.shiftClk, if3.shiftClk, if2.shiftClk, if1.shiftClk, if0.shiftClk};
    assign o_lclk = {if4.latchClk, if3.latchClk, if2.latchClk, if1.latchClk, if0.latchClk};

    // Single comparison point: counts the check and reports a mismatch.
    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_act  [NI];
    int          m_cnt  [NI];   // 1 = first cycle after acceptance
    logic [31:0] m_word [NI];
    bit          m_done [NI];
    bit          m_drop [NI];

    function automatic int total_len(input int i);
        return P_N[i] * 2 * P_D[i] + P_L[i];
    endfunction

    // Transfer-level model: a transfer occupies total_len cycles after
    // acceptance, then one IDLE cycle carries done.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                m_act[i]  <= 1'b0;
                m_cnt[i]  <= 0;
                m_done[i] <= 1'b0;
                m_drop[i] <= 1'b0;
            end else begin
                m_drop[i] <= rdy[i] && m_act[i];
                m_done[i] <= 1'b0;
                if (m_act[i]) begin
                    if (m_cnt[i] == total_len(i)) begin
                        m_act[i]  <= 1'b0;
                        m_cnt[i]  <= 0;
                        m_done[i] <= 1'b1;
                    end else begin
                        m_cnt[i] <= m_cnt[i] + 1;
                    end
                end else if (rdy[i]) begin
                    m_act[i]  <= 1'b1;
                    m_cnt[i]  <= 1;
                    m_word[i] <= din[i];
                end
            end
        end
    end

    // Packed prediction: [6]=serialOut defined, [5]=busy, [4]=done,
    // [3]=dropped, [2]=serialOut, [1]=shiftClk, [0]=latchClk.
    function automatic logic [6:0] model_out(input int i);
        logic [6:0] r;
        int k, b, sub;
        r    = 7'b0;
        r[4] = m_done[i];
        r[3] = m_drop[i];
        if (!m_act[i]) begin
            r[6] = 1'b1;
        end else begin
            r[5] = 1'b1;
            k = m_cnt[i] - 1;
            if (k < P_N[i] * 2 * P_D[i]) begin
                b    = k / (2 * P_D[i]);
                sub  = k % (2 * P_D[i]);
                r[1] = (sub >= P_D[i]);
                r[2] = (P_M[i] != 0) ? m_word[i][P_N[i] - 1 - b] : m_word[i][b];
                r[6] = 1'b1;
            end else begin
                r[0] = 1'b1;
            end
        end
        return r;
    endfunction

    // Bits in shift order, first shifted bit ends up most significant.
    function automatic logic [31:0] exp_cap(input int i);
        logic [31:0] c;
        c = 32'h0;
        for (int b = 0; b < P_N[i]; b++) begin
            c = {c[30:0], (P_M[i] != 0) ? m_word[i][P_N[i] - 1 - b] : m_word[i][b]};
        end
        return c;
    endfunction

    logic [6:0] e_out [NI];
    always_comb begin
        e_out = '{default: 7'b0};
        for (int i = 0; i < NI; i++) begin
            e_out[i] = model_out(i);
        end
    end

    // ---------------- monitor ----------------
    bit          t_pb    [NI];
    bit          t_ps    [NI];
    bit          t_first [NI];
    int          t_len   [NI];
    int          t_rise  [NI];
    logic [31:0] t_cap   [NI];

    // Per-cycle pin comparison plus per-transfer length/edge/bit checks.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk_eq($sformatf("u%0d_busy", i),     {31'b0, o_busy[i]}, {31'b0, e_out[i][5]});
            chk_eq($sformatf("u%0d_done", i),     {31'b0, o_done[i]}, {31'b0, e_out[i][4]});
            chk_eq($sformatf("u%0d_dropped", i),  {31'b0, o_drop[i]}, {31'b0, e_out[i][3]});
            chk_eq($sformatf("u%0d_shiftClk", i), {31'b0, o_sclk[i]}, {31'b0, e_out[i][1]});
            chk_eq($sformatf("u%0d_latchClk", i), {31'b0, o_lclk[i]}, {31'b0, e_out[i][0]});
            if (e_out[i][6]) begin
                chk_eq($sformatf("u%0d_serialOut", i), {31'b0, o_ser[i]}, {31'b0, e_out[i][2]});
            end

            if (o_busy[i] && !t_pb[i]) begin
                t_len[i]  <= 1;
                t_rise[i] <= 0;
                t_cap[i]  <= 32'h0;
            end else if (o_busy[i]) begin
                t_len[i] <= t_len[i] + 1;
                if (o_sclk[i] && !t_ps[i]) begin
                    t_rise[i] <= t_rise[i] + 1;
                    t_cap[i]  <= {t_cap[i][30:0], o_ser[i]};
                end
            end else if (t_pb[i] && o_done[i]) begin
                chk_eq($sformatf("u%0d_busy_len", i), t_len[i], EXP_LEN[i]);
                chk_eq($sformatf("u%0d_rises", i), t_rise[i], P_N[i]);
                chk_eq($sformatf("u%0d_bits", i), t_cap[i], exp_cap(i));
                if (!t_first[i]) begin
                    chk_eq($sformatf("u%0d_first_bits", i), t_cap[i], FIRST_CAP[i]);
                    t_first[i] <= 1'b1;
                end
            end
            t_pb[i] <= o_busy[i];
            t_ps[i] <= o_sclk[i];
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cnt(input int i, input int val, input int limit);
        for (int n = 0; n < limit && m_cnt[i] != val; n++) @(negedge clk);
        chk_eq("wait_cnt", m_cnt[i], val);
    endtask

    task automatic wait_done(input int i, input int limit);
        for (int n = 0; n < limit && !m_done[i]; n++) @(negedge clk);
        chk_eq("wait_done", {31'b0, m_done[i]}, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) din[i] = 32'h0;
        repeat (3) @(negedge clk);
        rst = 5'b00000;
        @(negedge clk);

        // First directed transfer on every instance.
        rdy    = 5'b11111;
        din[0] = 32'hC4;
        din[1] = 32'hC4;
        din[2] = 32'hA;
        din[3] = 32'hA;
        din[4] = 32'h800001;
        @(negedge clk);
        rdy = 5'b00000;
        for (int i = 0; i < NI; i++) din[i] = $urandom;

        // Collision in cycle 5 of u0's transfer with a different word.
        wait_cnt(0, 5, 100);
        rdy[0] = 1'b1;
        din[0] = 32'h3B;
        @(negedge clk);
        rdy[0] = 1'b0;
        chk_eq("u0_dropped_pulse", {31'b0, o_drop[0]}, 32'h1);

        // Request in the done cycle starts the next transfer immediately.
        wait_done(0, 100);
        chk_eq("u0_done_seen", {31'b0, o_done[0]}, 32'h1);
        rdy[0] = 1'b1;
        din[0] = 32'h5A;
        @(negedge clk);
        rdy[0] = 1'b0;
        chk_eq("u0_busy_after_done", {31'b0, o_busy[0]}, 32'h1);

        // Reset after the third shiftClk rise of the 0x5A transfer.
        wait_cnt(0, 11, 100);
        chk_eq("u0_third_rise_high", {31'b0, o_sclk[0]}, 32'h1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk_eq("u0_outs_after_reset",
               {26'b0, o_busy[0], o_done[0], o_drop[0], o_ser[0], o_sclk[0], o_lclk[0]}, 32'h0);

        // A fresh transfer after the abort completes normally.
        rdy[0] = 1'b1;
        din[0] = 32'hFF;
        @(negedge clk);
        rdy[0] = 1'b0;
        wait_done(0, 100);
        wait_done(4, 400);

        // Randomised traffic, with a held strobe window and rare resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                rdy[i] = ($urandom_range(0, 15) == 0);
                din[i] = $urandom;
                rst[i] = ($urandom_range(0, 799) == 0);
            end
            if (n >= 1000 && n < 1120) rdy[2] = 1'b1;
        end
        @(negedge clk);
        rdy = 5'b00000;
        rst = 5'b00000;
        repeat (300) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
